// File: rtl/axis_pattern_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_pattern_generator                                          |
// | Brief    : AXI4-Stream video test-pattern source with optional tvalid      |
// |            bubbles and a completed-frame counter.                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axis_pattern_generator #(
  parameter int H_RES          = 1920,
  parameter int V_RES          = 1080,
  parameter int PIXELS_PER_CLK = 1,
  parameter int BITS_PER_CH    = 8,
  parameter int BUBBLE_PERIOD  = 0,
  parameter int BUBBLE_LEN     = 4
) (
  input  logic                                      sys_clk_i,
  input  logic                                      reset_i,
  input  logic                                      enable_i,
  input  logic [2:0]                                pattern_sel_i,
  input  logic                                      tready,
  output logic                                      tvalid,
  output logic [3*BITS_PER_CH*PIXELS_PER_CLK-1:0]   tdata,
  output logic                                      tuser,
  output logic                                      tlast,
  output logic [15:0]                               frame_count_o
);

  localparam int c_pix_w  = 3 * BITS_PER_CH;
  localparam int c_data_w = c_pix_w * PIXELS_PER_CLK;
  localparam int c_x_w    = $clog2(H_RES) + 1;
  localparam int c_y_w    = $clog2(V_RES) + 1;
  localparam int c_bc_w   = $clog2(BUBBLE_PERIOD + 2);

  localparam logic [c_x_w-1:0]       c_last_x      = c_x_w'(H_RES - PIXELS_PER_CLK);
  localparam logic [c_y_w-1:0]       c_last_y      = c_y_w'(V_RES - 1);
  localparam logic [c_x_w-1:0]       c_step_x      = c_x_w'(PIXELS_PER_CLK);
  localparam logic [c_y_w-1:0]       c_one_y       = c_y_w'(1);
  localparam logic [c_bc_w-1:0]      c_one_bc      = c_bc_w'(1);
  localparam logic [c_bc_w-1:0]      c_period      = c_bc_w'(BUBBLE_PERIOD);
  localparam logic [7:0]             c_bubble_last = 8'(BUBBLE_LEN - 1);
  localparam logic [BITS_PER_CH-1:0] c_full        = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_x_w-1:0]    r_x;
  logic [c_y_w-1:0]    r_y;
  logic [2:0]          r_pattern;
  logic [c_bc_w-1:0]   r_beat_cnt;
  logic [7:0]          r_bub_cnt;

  logic                w_eol;
  logic                w_eof;
  logic [c_x_w-1:0]    w_nx;
  logic [c_y_w-1:0]    w_ny;
  logic [c_x_w-1:0]    w_ld_x;
  logic [c_y_w-1:0]    w_ld_y;
  logic [2:0]          w_ld_pat;
  logic                w_ld_first;
  logic                w_ld_last;
  logic [c_bc_w-1:0]   w_cnt_inc;
  logic                w_take_bubble;
  logic [c_data_w-1:0] w_pix;

  // Bar index is found by comparing against the seven fixed bar edges.
  function automatic logic [c_pix_w-1:0] gen_pixel(input logic [c_x_w-1:0] col,
                                                   input logic [c_y_w-1:0] row,
                                                   input logic [2:0]       pat);
    logic [2:0]             bar_x;
    logic [2:0]             bar_y;
    logic [2:0]             bar;
    logic [BITS_PER_CH-1:0] r;
    logic [BITS_PER_CH-1:0] g;
    logic [BITS_PER_CH-1:0] b;
    bar_x = '0;
    bar_y = '0;
    for (int k = 1; k < 8; k++) begin
      if (col >= c_x_w'(k * (H_RES / 8))) bar_x = bar_x + 3'd1;
      if (row >= c_y_w'(k * (V_RES / 8))) bar_y = bar_y + 3'd1;
    end
    bar = (pat == 3'd4) ? bar_y : bar_x;
    r = '0;
    g = '0;
    b = '0;
    case (pat)
      3'd0, 3'd4: begin
        r = bar[2] ? c_full : '0;
        g = bar[1] ? c_full : '0;
        b = bar[0] ? c_full : '0;
      end
      3'd1: r = c_full;
      3'd2: g = c_full;
      3'd3: b = c_full;
      3'd5: begin
        r = BITS_PER_CH'(col);
        g = BITS_PER_CH'(col);
        b = BITS_PER_CH'(col);
      end
      3'd6: begin
        r = BITS_PER_CH'(row);
        g = BITS_PER_CH'(row);
        b = BITS_PER_CH'(row);
      end
      default: begin
        r = (col[3] ^ row[3]) ? c_full : '0;
        g = (col[3] ^ row[3]) ? c_full : '0;
        b = (col[3] ^ row[3]) ? c_full : '0;
      end
    endcase
    return {b, g, r};
  endfunction

  assign w_eol = (r_x == c_last_x);
  assign w_eof = w_eol && (r_y == c_last_y);
  assign w_nx  = w_eol ? '0 : (r_x + c_step_x);
  assign w_ny  = w_eol ? (w_eof ? '0 : (r_y + c_one_y)) : r_y;

  // Coordinates and pattern of the beat that gets registered next.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_ld_x   = '0;
      w_ld_y   = '0;
      w_ld_pat = pattern_sel_i;
    end else begin
      w_ld_x   = w_nx;
      w_ld_y   = w_ny;
      w_ld_pat = w_eof ? pattern_sel_i : r_pattern;
    end
  end

  assign w_ld_first = (w_ld_x == '0) && (w_ld_y == '0);
  assign w_ld_last  = (w_ld_x == c_last_x);

  assign w_cnt_inc     = r_beat_cnt + c_one_bc;
  assign w_take_bubble = (BUBBLE_PERIOD != 0) && (w_cnt_inc == c_period);

  for (genvar p = 0; p < PIXELS_PER_CLK; p++) begin : g_pix
    assign w_pix[p*c_pix_w +: c_pix_w] = gen_pixel(w_ld_x + c_x_w'(p), w_ld_y, w_ld_pat);
  end

  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state       <= ST_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_pattern     <= '0;
      r_beat_cnt    <= '0;
      r_bub_cnt     <= '0;
      tvalid        <= 1'b0;
      tdata         <= '0;
      tuser         <= 1'b0;
      tlast         <= 1'b0;
      frame_count_o <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_x        <= '0;
            r_y        <= '0;
            r_pattern  <= pattern_sel_i;
            r_beat_cnt <= '0;
            tdata      <= w_pix;
            tuser      <= w_ld_first;
            tlast      <= w_ld_last;
            tvalid     <= 1'b1;
            r_state    <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (tready) begin
            r_x <= w_nx;
            r_y <= w_ny;
            if (w_eof) begin
              frame_count_o <= frame_count_o + 16'd1;
              r_pattern     <= pattern_sel_i;
            end
            // Stopping at a frame end takes priority over a due bubble.
            if (w_eof && !enable_i) begin
              tvalid  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              tdata <= w_pix;
              tuser <= w_ld_first;
              tlast <= w_ld_last;
              if (w_take_bubble) begin
                r_beat_cnt <= '0;
                r_bub_cnt  <= '0;
                tvalid     <= 1'b0;
                r_state    <= ST_BUBBLE;
              end else begin
                r_beat_cnt <= w_cnt_inc;
              end
            end
          end
        end

        ST_BUBBLE: begin
          if (r_bub_cnt == c_bubble_last) begin
            tvalid  <= 1'b1;
            r_state <= ST_ACTIVE;
          end else begin
            r_bub_cnt <= r_bub_cnt + 8'd1;
          end
        end

        default: begin
          tvalid  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_pattern_generator                                       |
// | Brief    : Directed self-checking bench for axis_pattern_generator.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_axis_pattern_generator;

  localparam int HR = 16;
  localparam int VR = 8;

  logic sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  logic        reset_i;
  logic        en1, en2, en3;
  logic [2:0]  sel1, sel2, sel3;
  logic        rdy1, rdy2, rdy3;
  logic        tv1, tu1, tl1, tv2, tu2, tl2, tv3, tu3, tl3;
  logic [23:0] td1, td3;
  logic [47:0] td2;
  logic [15:0] fc1, fc2, fc3;

  axis_pattern_generator #(.H_RES(HR), .V_RES(VR), .PIXELS_PER_CLK(1), .BITS_PER_CH(8),
                           .BUBBLE_PERIOD(0), .BUBBLE_LEN(4)) dut (
    .sys_clk_i(sys_clk_i), .reset_i(reset_i), .enable_i(en1), .pattern_sel_i(sel1),
    .tready(rdy1), .tvalid(tv1), .tdata(td1), .tuser(tu1), .tlast(tl1), .frame_count_o(fc1));

  axis_pattern_generator #(.H_RES(HR), .V_RES(VR), .PIXELS_PER_CLK(2), .BITS_PER_CH(8),
                           .BUBBLE_PERIOD(0), .BUBBLE_LEN(4)) dut2 (
    .sys_clk_i(sys_clk_i), .reset_i(reset_i), .enable_i(en2), .pattern_sel_i(sel2),
    .tready(rdy2), .tvalid(tv2), .tdata(td2), .tuser(tu2), .tlast(tl2), .frame_count_o(fc2));

  axis_pattern_generator #(.H_RES(HR), .V_RES(VR), .PIXELS_PER_CLK(1), .BITS_PER_CH(8),
                           .BUBBLE_PERIOD(5), .BUBBLE_LEN(3)) dut3 (
    .sys_clk_i(sys_clk_i), .reset_i(reset_i), .enable_i(en3), .pattern_sel_i(sel3),
    .tready(rdy3), .tvalid(tv3), .tdata(td3), .tuser(tu3), .tlast(tl3), .frame_count_o(fc3));

  typedef struct {
    int          beat;
    logic [23:0] data;
    logic        user;
    logic        last;
  } vec_t;

  vec_t        vecs[13];
  logic [23:0] cap_d[128];
  logic        cap_u[128];
  logic        cap_l[128];
  logic [47:0] d2[9];
  logic        u2[9];
  logic        l2[9];
  int          checks   = 0;
  int          failures = 0;

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] model_pix(input int col, input int row, input int pat);
    int         bar;
    logic [7:0] r, g, b;
    r = 8'h00; g = 8'h00; b = 8'h00;
    bar = (pat == 4) ? (row * 8 / VR) : (col * 8 / HR);
    case (pat)
      0, 4: begin
        if ((bar & 4) != 0) r = 8'hFF;
        if ((bar & 2) != 0) g = 8'hFF;
        if ((bar & 1) != 0) b = 8'hFF;
      end
      1: r = 8'hFF;
      2: g = 8'hFF;
      3: b = 8'hFF;
      5: begin r = 8'(col % 256); g = r; b = r; end
      6: begin r = 8'(row % 256); g = r; b = r; end
      default: if ((((col >> 3) ^ (row >> 3)) & 1) != 0) begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
    endcase
    return {b, g, r};
  endfunction

  // Streams n beats from dut, checking each against the model and
  // checking that a stalled beat is held until it is taken.
  task automatic stream1(input int n, input bit rnd, input int pat, input int hook_beat,
                         input logic hook_en, input logic [2:0] hook_sel, output int cycles);
    int          beats;
    logic        held;
    logic [25:0] held_v;
    beats = 0; cycles = 0; held = 1'b0; held_v = '0;
    while (beats < n && cycles < 4000) begin
      rdy1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) chk("stall_hold", 64'({tv1, tu1, tl1, td1}), 64'({1'b1, held_v}));
      if (tv1 && rdy1) begin
        chk("beat_data", 64'(td1), 64'(model_pix(beats % HR, beats / HR, pat)));
        chk("beat_tuser", 64'(tu1), 64'(beats == 0));
        chk("beat_tlast", 64'(tl1), 64'((beats % HR) == HR - 1));
        cap_d[beats] = td1;
        cap_u[beats] = tu1;
        cap_l[beats] = tl1;
        if (beats == hook_beat) begin
          en1  = hook_en;
          sel1 = hook_sel;
        end
        beats++;
      end
      held   = tv1 && !rdy1;
      held_v = {tu1, tl1, td1};
      tick();
      cycles++;
    end
    if (beats < n) chk("stream_timeout", 64'(beats), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int beat;

    vecs[0]  = '{0,   24'h000000, 1'b1, 1'b0};
    vecs[1]  = '{1,   24'h000000, 1'b0, 1'b0};
    vecs[2]  = '{2,   24'hFF0000, 1'b0, 1'b0};
    vecs[3]  = '{3,   24'hFF0000, 1'b0, 1'b0};
    vecs[4]  = '{4,   24'h00FF00, 1'b0, 1'b0};
    vecs[5]  = '{6,   24'hFFFF00, 1'b0, 1'b0};
    vecs[6]  = '{8,   24'h0000FF, 1'b0, 1'b0};
    vecs[7]  = '{10,  24'hFF00FF, 1'b0, 1'b0};
    vecs[8]  = '{12,  24'h00FFFF, 1'b0, 1'b0};
    vecs[9]  = '{14,  24'hFFFFFF, 1'b0, 1'b0};
    vecs[10] = '{15,  24'hFFFFFF, 1'b0, 1'b1};
    vecs[11] = '{16,  24'h000000, 1'b0, 1'b0};
    vecs[12] = '{127, 24'hFFFFFF, 1'b0, 1'b1};

    reset_i = 1'b0;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    sel1 = 3'd0; sel2 = 3'd0; sel3 = 3'd0;
    rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
    tick(); tick();
    chk("reset_tvalid", 64'(tv1), 64'(0));
    chk("reset_tdata", 64'(td1), 64'(0));
    chk("reset_tuser", 64'(tu1), 64'(0));
    chk("reset_tlast", 64'(tl1), 64'(0));
    chk("reset_frame_count", 64'(fc1), 64'(0));
    reset_i = 1'b1;
    tick();

    // Frame 1: colour bars; the pattern select changes mid-frame.
    sel1 = 3'd0; en1 = 1'b1; rdy1 = 1'b1;
    tick();
    chk("start_tvalid", 64'(tv1), 64'(1));
    chk("start_tuser", 64'(tu1), 64'(1));
    stream1(128, 1'b0, 0, 40, 1'b1, 3'd7, cyc);
    chk("frame1_cycles", 64'(cyc), 64'(128));
    chk("frame1_count", 64'(fc1), 64'(1));
    chk("frame2_no_gap", 64'({tv1, tu1}), 64'(2'b11));
    for (int i = 0; i < 13; i++) begin
      chk("vec_data", 64'(cap_d[vecs[i].beat]), 64'(vecs[i].data));
      chk("vec_tuser", 64'(cap_u[vecs[i].beat]), 64'(vecs[i].user));
      chk("vec_tlast", 64'(cap_l[vecs[i].beat]), 64'(vecs[i].last));
    end

    // Frame 2: checkerboard under random backpressure; enable drops mid-frame.
    stream1(128, 1'b1, 7, 60, 1'b0, 3'd1, cyc);
    chk("frame2_idle", 64'(tv1), 64'(0));
    chk("frame2_count", 64'(fc1), 64'(2));
    tick(); tick(); tick();
    chk("idle_hold", 64'(tv1), 64'(0));

    en1 = 1'b1;
    tick();
    chk("reenable_tvalid", 64'(tv1), 64'(1));
    chk("reenable_red", 64'(td1), 64'(24'h0000FF));
    stream1(50, 1'b0, 1, -1, 1'b1, 3'd1, cyc);

    // PIXELS_PER_CLK=2 horizontal grey ramp.
    sel2 = 3'd5; en2 = 1'b1; rdy2 = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("ppc2_tvalid", 64'(tv2), 64'(1));
      d2[i] = td2; u2[i] = tu2; l2[i] = tl2;
      tick();
    end
    en2 = 1'b0;
    chk("ppc2_b0_data", 64'(d2[0]), 64'(48'h010101_000000));
    chk("ppc2_b0_tuser", 64'(u2[0]), 64'(1));
    chk("ppc2_b3_tlast", 64'(l2[3]), 64'(0));
    chk("ppc2_b7_data", 64'(d2[7]), 64'(48'h0F0F0F_0E0E0E));
    chk("ppc2_b7_tlast", 64'(l2[7]), 64'(1));
    chk("ppc2_b8_data", 64'(d2[8]), 64'(48'h010101_000000));
    chk("ppc2_b8_tuser", 64'(u2[8]), 64'(0));

    // Bubbles: 5 beats valid, 3 cycles empty, repeating.
    sel3 = 3'd0; en3 = 1'b1; rdy3 = 1'b1;
    tick();
    beat = 0;
    for (int c = 0; c < 64; c++) begin
      chk("bubble_tvalid", 64'(tv3), 64'((c % 8) < 5));
      if (tv3) begin
        chk("bubble_data", 64'(td3), 64'(model_pix(beat % HR, beat / HR, 0)));
        beat++;
      end
      tick();
    end
    en3 = 1'b0;
    chk("bubble_beats", 64'(beat), 64'(40));

    // Asynchronous reset in the middle of a frame.
    #2;
    reset_i = 1'b0;
    #1;
    chk("async_rst_tvalid", 64'(tv1), 64'(0));
    chk("async_rst_tdata", 64'(td1), 64'(0));
    chk("async_rst_tuser_tlast", 64'({tu1, tl1}), 64'(0));
    chk("async_rst_frame_count", 64'(fc1), 64'(0));
    tick();
    reset_i = 1'b1;
    sel1 = 3'd5; en1 = 1'b1; rdy1 = 1'b1;
    tick();
    chk("restart_tvalid", 64'(tv1), 64'(1));
    chk("restart_tuser", 64'(tu1), 64'(1));
    chk("restart_x0", 64'(td1), 64'(24'h000000));
    chk("restart_frame_count", 64'(fc1), 64'(0));
    tick();
    chk("restart_x1", 64'({tu1, td1}), 64'({1'b0, 24'h010101}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pattern_generator.md
# axis_pattern_generator

Parametrised AXI4-Stream video test-pattern source for the AXIS-to-VGA converter testbench and for on-board bring-up. It emits frames of H_RES×V_RES pixels, PIXELS_PER_CLK pixels per beat, with full AXI4-Stream backpressure compliance. It generates 8 selectable patterns, optionally inserts periodic tvalid bubbles, and keeps a frame counter.

## Interface
- H_RES, 1920: active pixels per line; multiple of 8×PIXELS_PER_CLK.
- V_RES, 1080: active lines per frame; multiple of 8.
- PIXELS_PER_CLK, 1: pixels per beat; 1, 2 or 4.
- BITS_PER_CH, 8: bits per colour channel; 8 or 10.
- BUBBLE_PERIOD, 0: transferred beats between bubbles; 0 disables bubbles.
- BUBBLE_LEN, 4: bubble length in cycles (tvalid=0); 1..255.
- sys_clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  start/continue streaming; sampled at frame boundaries.
- pattern_sel_i  in  3  pattern select; latched at frame start.
- tready  in  1  AXI4-Stream sink ready.
- tvalid  out  1  beat valid.
- tdata  out  3×BITS_PER_CH×PIXELS_PER_CLK  pixels. Pixel p occupies [p×3×BITS_PER_CH +: 3×BITS_PER_CH], internally {blue, green, red} with red in the LSBs. Pixel 0 is the leftmost.
- tuser  out  1  start of frame; asserted on the beat with x=0, y=0.
- tlast  out  1  end of line; asserted on the beat with x=H_RES−PIXELS_PER_CLK.
- frame_count_o  out  16  completed frames; wraps 0xFFFF→0.

## Operation
- States:
  - IDLE: tvalid=0. If enable_i=1, load x=0, y=0, latch pattern_sel_i, present beat (0,0), go to ACTIVE.
  - ACTIVE: tvalid=1.
  - BUBBLE: tvalid=0; counts BUBBLE_LEN cycles, then returns to ACTIVE.
- A transfer occurs when tvalid&tready. Only transfers advance state. x advances by PIXELS_PER_CLK.
- At end of line: x=0 and y increments.
- At end of frame (last beat of line V_RES−1): y=0, frame_count_o+1, pattern_sel_i relatched. If enable_i=0 at that transfer, go to IDLE.
- enable_i deassertion mid-frame has no effect; the frame always completes.
- Bubbles: a beat counter counts transferred beats and resets at frame start. When it reaches BUBBLE_PERIOD, the counter clears and the state goes to BUBBLE after that transfer. This applies across line and frame boundaries, except that an end-of-frame transfer with enable_i=0 goes to IDLE and no bubble is taken.
- Patterns use F = 2^BITS_PER_CH−1 and pixel column x+p:
  - 0: vertical colour bars. Bar b = floor(col×8/H_RES); R=F if b[2], G=F if b[1], B=F if b[0].
  - 1: solid red (R=F, others 0).
  - 2: solid green.
  - 3: solid blue.
  - 4: horizontal colour bars. b = floor(y×8/V_RES), same colour mapping as pattern 0.
  - 5: horizontal grey ramp, R=G=B=col mod 2^BITS_PER_CH.
  - 6: vertical grey ramp, R=G=B=y mod 2^BITS_PER_CH.
  - 7: checkerboard. White (F) if (col[3]^y[3])=1, else black.
- Bar thresholds are elaboration-time constants. No runtime divider is used.

## Timing
- All outputs are registered. Reset values: tvalid=0, tdata=0, tuser=0, tlast=0, frame_count_o=0. State resets to IDLE.
- Start latency: enable_i=1 sampled at edge N gives tvalid=1 with beat (0,0) after edge N.
- While tvalid=1 and tready=0, tdata, tuser and tlast hold stable. tvalid is never dropped without a transfer.
- tvalid does not depend combinationally on tready.
- Throughput with tready=1 and no bubbles: one beat per cycle, with no gaps between lines or frames.
- BUBBLE: exactly BUBBLE_LEN cycles with tvalid=0, independent of tready.
- pattern_sel_i changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). After release, streaming restarts from (0,0) at the next enable.

## Test plan
All scenarios use H_RES=16, V_RES=8, BITS_PER_CH=8 unless stated.
- PIXELS_PER_CLK=1, pattern 0, tready=1 -> tdata per x:
  - x0..1 = 0x000000
  - x2..3 = 0xFF0000
  - x4..5 = 0x00FF00
  - x14..15 = 0xFFFFFF
  - tlast at x=15; tuser only on the first beat; 128 beats per frame; frame_count_o=1 after the first frame.
- PIXELS_PER_CLK=2, pattern 5 -> 8 beats per line; beat 0 tdata = 0x010101_000000; tlast on beat 7 = 0x0F0F0F_0E0E0E.
- Random tready (50%), pattern 7 -> tdata/tuser/tlast stable across every stall cycle; checkerboard matches the reference model; no lost or duplicated beats.
- BUBBLE_PERIOD=5, BUBBLE_LEN=3, tready=1 -> tvalid low for exactly 3 cycles after every 5th transfer; beat sequence unchanged.
- pattern_sel_i switches 0→1 at beat 40, enable_i drops at beat 60 -> the frame completes with pattern 0 (128 beats), then tvalid=0 and state is IDLE; re-enable gives solid red 0x0000FF.
- reset_i low at beat 50 -> all outputs 0 the same cycle; after release and enable, the first beat has tuser=1 and x=0, and frame_count_o=0.
